// File: rtl/nmi_req_pkg.sv
// rtl/nmi_req_pkg.sv - shared defaults and request bit indices for the NMI request path
package nmi_req_pkg;
   localparam int NMI_DEB_W_DEF   = 16;
   localparam int NMI_STB_LEN_DEF = 4;
   localparam int NMI_REQ_W       = 2;
   localparam int NMI_REQ_BTN     = 0;
   localparam int NMI_REQ_SPI     = 1;

   typedef logic [NMI_REQ_W-1:0] nmi_req_t;
endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - 2-flop synchroniser plus counter debounce for an active-low pin
// Outputs a pressed-high level and one-cycle rise/fall pulses coincident with the level change.
module sync_debounce #(
   parameter int DEB_W = 16
) (
   input  logic fclk,
   input  logic rst_n,
   input  logic raw_n_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic             s1_q, s2_q;
   logic             lvl_q, lvl_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;
   logic             mism, done;

   assign mism = (s2_q != lvl_q);
   assign done = mism & (&cnt_q);

   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (!mism) begin
         cnt_d = '0;
      end else if (done) begin
         cnt_d = '0;
         lvl_d = ~lvl_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // lvl_q keeps pin polarity (1 = released) so reset matches an idle pin
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= 1'b1;
         s2_q  <= 1'b1;
         lvl_q <= 1'b1;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw_n_i;
         s2_q  <= s1_q;
         lvl_q <= lvl_d;
         cnt_q <= cnt_d;
      end
   end

   assign level_o = ~lvl_q;
   assign rise_o  = done & lvl_q;
   assign fall_o  = done & ~lvl_q;
endmodule

// File: rtl/nmi_req.sv
// rtl/nmi_req.sv - builds glitch-free NMI request levels from the magic button and SPI strobe
// Each set_nmi bit's falling edge is one request to the downstream NMI stage.
module nmi_req
   import nmi_req_pkg::*;
#(
   parameter int DEB_W   = NMI_DEB_W_DEF,
   parameter int STB_LEN = NMI_STB_LEN_DEF
) (
   input  logic                 fclk,
   input  logic                 rst_n,
   input  logic                 btn_n,
   input  logic                 spi_nmi_stb,
   input  logic                 in_nmi,
   output logic [NMI_REQ_W-1:0] set_nmi,
   output logic                 btn_state
);
   localparam int STB_W = $clog2(STB_LEN + 1);

   logic             pressed, rise, fall;
   logic             armed_q, armed_d;
   logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
   nmi_req_t         set_q, set_d;

   sync_debounce #(.DEB_W(DEB_W)) u_deb (
      .fclk    (fclk),
      .rst_n   (rst_n),
      .raw_n_i (btn_n),
      .level_o (pressed),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // armed is decided once per press, so in_nmi changes mid-press cannot create an edge
   always_comb begin
      armed_d = armed_q;
      if (rise) begin
         armed_d = ~in_nmi;
      end else if (fall) begin
         armed_d = 1'b0;
      end

      stb_cnt_d = stb_cnt_q;
      if (spi_nmi_stb && !in_nmi) begin
         stb_cnt_d = STB_W'(STB_LEN);
      end else if (stb_cnt_q != '0) begin
         stb_cnt_d = stb_cnt_q - 1'b1;
      end

      set_d              = '0;
      set_d[NMI_REQ_BTN] = armed_q & pressed;
      set_d[NMI_REQ_SPI] = (stb_cnt_q != '0);
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q   <= 1'b0;
         stb_cnt_q <= '0;
         set_q     <= '0;
      end else begin
         armed_q   <= armed_d;
         stb_cnt_q <= stb_cnt_d;
         set_q     <= set_d;
      end
   end

   assign set_nmi   = set_q;
   assign btn_state = pressed;
endmodule

// File: tb/tb_nmi_req.sv
// tb/tb_nmi_req.sv - vector-queue bench for nmi_req with DEB_W=4, STB_LEN=4
module tb_nmi_req;
   logic       fclk;
   logic       rst_n;
   logic       btn_n;
   logic       spi_nmi_stb;
   logic       in_nmi;
   logic [1:0] set_nmi;
   logic       btn_state;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int         tid;
      int         cyc;
      logic       btn_n;
      logic       stb;
      logic       in_nmi;
      logic [2:0] exp;   // {set_nmi[1], set_nmi[0], btn_state}
   } vec_t;

   vec_t vq[$];

   nmi_req #(.DEB_W(4), .STB_LEN(4)) dut (
      .fclk        (fclk),
      .rst_n       (rst_n),
      .btn_n       (btn_n),
      .spi_nmi_stb (spi_nmi_stb),
      .in_nmi      (in_nmi),
      .set_nmi     (set_nmi),
      .btn_state   (btn_state)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got set_nmi=%b btn_state=%b, want set_nmi=%b btn_state=%b",
                  nm, got[2:1], got[0], want[2:1], want[0]);
      end
   endtask

   task automatic push(input int t, input int c, input bit b, input bit s, input bit n,
                       input bit e1, input bit e0, input bit eb);
      vec_t v;
      v.tid = t; v.cyc = c; v.btn_n = b; v.stb = s; v.in_nmi = n;
      v.exp = {e1, e0, eb};
      vq.push_back(v);
   endtask

   // Vector i is driven just after an edge; its expectation is sampled 1ns after the next edge.
   task automatic run_q();
      vec_t v;
      while (vq.size() > 0) begin
         v = vq.pop_front();
         btn_n       = v.btn_n;
         spi_nmi_stb = v.stb;
         in_nmi      = v.in_nmi;
         @(posedge fclk);
         #1;
         chk($sformatf("t%0d cyc%0d", v.tid, v.cyc), {set_nmi, btn_state}, v.exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; btn_n = 1'b1; spi_nmi_stb = 1'b0; in_nmi = 1'b0;
      repeat (3) @(posedge fclk);
      #1;
      chk("reset", {set_nmi, btn_state}, 3'b000);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) push(0, i, 1, 0, 0, 0, 0, 0);
      run_q();

      // clean press at 5, release at 45: btn_state after 18 edges, set_nmi[0] one later
      for (int i = 0; i < 80; i++)
         push(1, i, !(i >= 5 && i < 45), 0, 0, 0, (i >= 23 && i < 63), (i >= 22 && i < 62));
      run_q();

      // bounce every 5 cycles never debounces
      for (int i = 0; i < 100; i++) push(2, i, ((i / 5) % 2) != 0, 0, 0, 0, 0, 0);
      for (int i = 100; i < 130; i++) push(2, i, 1, 0, 0, 0, 0, 0);
      run_q();

      // press begins inside NMI, in_nmi drops mid-press: bit 0 never moves
      for (int i = 0; i < 80; i++)
         push(3, i, !(i >= 5 && i < 50), 0, (i < 30), 0, 0, (i >= 22 && i < 67));
      run_q();

      // single strobe at 10
      for (int i = 0; i < 25; i++) push(4, i, 1, (i == 10), 0, (i >= 11 && i <= 14), 0, 0);
      run_q();
      // strobes at 10 and 12: one extended pulse
      for (int i = 0; i < 25; i++)
         push(5, i, 1, (i == 10 || i == 12), 0, (i >= 11 && i <= 16), 0, 0);
      run_q();
      // strobe during NMI is dropped
      for (int i = 0; i < 15; i++) push(6, i, 1, (i == 5), (i == 5), 0, 0, 0);
      run_q();

      // button and SPI together, each bit on its own timing
      for (int i = 0; i < 80; i++)
         push(7, i, !(i >= 5 && i < 45), (i == 23), 0,
              (i >= 24 && i <= 27), (i >= 23 && i < 63), (i >= 22 && i < 62));
      run_q();

      // reach set_nmi=11, then reset asynchronously mid-pulse
      for (int i = 0; i < 28; i++)
         push(8, i, !(i >= 5), (i == 25), 0, (i >= 26), (i >= 23), (i >= 22));
      run_q();
      #1 rst_n = 1'b0;
      #1;
      chk("async reset mid-pulse", {set_nmi, btn_state}, 3'b000);
      #1 rst_n = 1'b1;

      // held button re-detected with in_nmi=1: no arm; release; fresh press with in_nmi=0 arms
      for (int i = 0; i < 140; i++) begin
         bit b;
         b = !(i < 30 || (i >= 60 && i < 100));
         push(9, i, b, 0, (i < 30), 0,
              (i >= 78 && i < 118), ((i >= 17 && i < 47) || (i >= 77 && i < 117)));
      end
      run_q();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
